ps2_frame_receiver: RTL and testbench



---
 rtl/ps2_frame_receiver.sv | 163 ++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//   Receives PS/2 device-to-host frames from the raw pins, sampled in the CLOCK_50
//   domain. The E0 (extended) and F0 (break) prefixes are folded into flags, and
//   the block emits one single-cycle event per completed key code.
//
// Ports
//   CLOCK_50    in   system clock; all logic runs on its rising edge
//   resetn      in   asynchronous active-low reset
//   PS2_CLK     in   raw keyboard clock pin (asynchronous)
//   PS2_DAT     in   raw keyboard data pin (asynchronous)
//   code        out  last completed non-prefix scan code; holds between events
//   code_valid  out  one-cycle strobe; code/is_break/is_extended are valid
//   is_break    out  code was preceded by F0
//   is_extended out  code was preceded by E0
//   frame_error out  one-cycle strobe on a rejected or aborted frame
//
// Handshake: code_valid is a pure strobe with no ready/back-pressure. Consumers
// must take code/is_break/is_extended in the cycle code_valid is high.
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_error
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;

    logic              clkMeta, clkSync;
    logic              datMeta, datSync;
    logic [FILT_W-1:0] filtCnt;
    logic              filtClk;
    logic              fall;
    state_e            state;
    logic [10:0]       shiftReg;
    logic [3:0]        bitCnt;
    logic [TO_W-1:0]   toCnt;
    logic              extPend, brkPend;
    logic              frameOk;
    logic [7:0]        rxByte;

    // Two-flop synchronizers. They reset to 1, which is the idle level of the lines.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clkMeta <= 1'b1;
            clkSync <= 1'b1;
            datMeta <= 1'b1;
            datSync <= 1'b1;
        end else begin
            clkMeta <= PS2_CLK;
            clkSync <= clkMeta;
            datMeta <= PS2_DAT;
            datSync <= datMeta;
        end
    end

    // Glitch filter. The filtered level follows the synchronized clock only after
    // FILTER_LEN consecutive differing samples. fall is high for one cycle, in the
    // cycle after the filtered level drops from 1 to 0.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            filtCnt <= '0;
            filtClk <= 1'b1;
            fall    <= 1'b0;
        end else if (clkSync != filtClk) begin
            if (filtCnt == FILT_LAST) begin
                filtClk <= clkSync;
                filtCnt <= '0;
                fall    <= filtClk;
            end else begin
                filtCnt <= filtCnt + 1'b1;
                fall    <= 1'b0;
            end
        end else begin
            filtCnt <= '0;
            fall    <= 1'b0;
        end
    end

    // Bits are shifted in at the MSB end, so after 11 falls the register reads
    // {stop, parity, data[7:0], start}.
    assign rxByte  = shiftReg[8:1];
    assign frameOk = ~shiftReg[0] & shiftReg[10] & (^shiftReg[9:1]);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            shiftReg    <= '0;
            bitCnt      <= '0;
            toCnt       <= '0;
            extPend     <= 1'b0;
            brkPend     <= 1'b0;
            code        <= 8'h00;
            code_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    toCnt <= '0;
                    if (fall) begin
                        shiftReg <= {datSync, shiftReg[10:1]};
                        bitCnt   <= 4'd1;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (fall) begin
                        shiftReg <= {datSync, shiftReg[10:1]};
                        bitCnt   <= bitCnt + 4'd1;
                        toCnt    <= '0;
                        if (bitCnt == 4'd10) state <= CHECK;
                    end else if (toCnt == TO_LAST) begin
                        // The keyboard stalled mid-frame. Drop the frame and any
                        // prefix it may belong to.
                        frame_error <= 1'b1;
                        extPend     <= 1'b0;
                        brkPend     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frameOk) begin
                        frame_error <= 1'b1;
                        extPend     <= 1'b0;
                        brkPend     <= 1'b0;
                    end else if (rxByte == 8'hE0) begin
                        extPend <= 1'b1;
                    end else if (rxByte == 8'hF0) begin
                        brkPend <= 1'b1;
                    end else begin
                        code        <= rxByte;
                        is_break    <= brkPend;
                        is_extended <= extPend;
                        code_valid  <= 1'b1;
                        extPend     <= 1'b0;
                        brkPend     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
module tb_ps2_frame_receiver;

    localparam int TO   = 1500;  // shortened timeout keeps the run small
    localparam int HALF = 60;    // half bit period in clock cycles

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [7:0] code;
    logic       code_valid, is_break, is_extended, frame_error;

    ps2_frame_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .code(code), .code_valid(code_valid), .is_break(is_break),
        .is_extended(is_extended), .frame_error(frame_error)
    );

    // clock / cycle counter
    always #10 CLOCK_50 = ~CLOCK_50;
    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Scoreboard entries are {err, brk, ext, code[7:0]}
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    int assert_cnt = 0;
    int fail_cnt   = 0;
    int last_fall_cyc = 0;
    int ev_cyc = 0;
    bit mdl_ext = 1'b0;
    bit mdl_brk = 1'b0;

    // event monitor
    always @(negedge CLOCK_50) begin
        if (code_valid) begin
            obs_q.push_back({1'b0, is_break, is_extended, code});
            ev_cyc = cyc;
        end
        if (frame_error) begin
            obs_q.push_back(11'h400);
            ev_cyc = cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame-level prefix folding.
    function automatic void model_frame(input logic [7:0] d, input bit good);
        if (!good) begin
            exp_q.push_back(11'h400);
            mdl_ext = 1'b0;
            mdl_brk = 1'b0;
        end else if (d == 8'hE0) begin
            mdl_ext = 1'b1;
        end else if (d == 8'hF0) begin
            mdl_brk = 1'b1;
        end else begin
            exp_q.push_back({1'b0, mdl_brk, mdl_ext, d});
            mdl_ext = 1'b0;
            mdl_brk = 1'b0;
        end
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    // driver: drives nbits of a frame LSB first, with an optional 3-cycle low
    // glitch in the high phase after bit glitch_at
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50);
            PS2_DAT = bits[i];
            wait_cyc(HALF);
            PS2_CLK = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            PS2_CLK = 1'b1;
            if (i == glitch_at) begin
                wait_cyc(HALF / 2);
                PS2_CLK = 1'b0;
                wait_cyc(3);
                PS2_CLK = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit bad, input int glitch_at);
        send_bits(mk_frame(d, bad), 11, glitch_at);
        model_frame(d, !bad);
        wait_cyc(40);
    endtask

    task automatic check_events(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_event"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_code"}, code, 8'h00);
        check({tag, "_code_valid"}, code_valid, 1'b0);
        check({tag, "_is_break"}, is_break, 1'b0);
        check({tag, "_is_extended"}, is_extended, 1'b0);
        check({tag, "_frame_error"}, frame_error, 1'b0);
    endtask

    initial begin
        int d;
        logic [7:0] rb;
        bit bad;

        // reset
        wait_cyc(5);
        check_idle_outputs("reset");
        resetn = 1'b1;
        wait_cyc(10);

        // 1: plain make code, latency from raw stop-bit fall
        send_byte(8'h1D, 1'b0, -1);
        d = ev_cyc - last_fall_cyc;
        check("t1_latency", (d >= 11 && d <= 13), 1'b1);
        check_events("t1");
        wait_cyc(20);
        check("t1_code_hold", code, 8'h1D);
        check("t1_valid_low", code_valid, 1'b0);

        // 2: break
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h1D, 1'b0, -1);
        check_events("t2");

        // 3: extended, extended break, then flags cleared
        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'h75, 1'b0, -1);
        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h75, 1'b0, -1);
        check_events("t3a");
        check("t3_brk_hold", is_break, 1'b1);
        send_byte(8'h1D, 1'b0, -1);
        check_events("t3b");

        // 4: bad parity, and bad parity clearing a pending prefix
        send_byte(8'h1D, 1'b1, -1);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h1D, 1'b1, -1);
        send_byte(8'h1D, 1'b0, -1);
        check_events("t4");

        // 5: timeout after five bits; pending F0 must be dropped
        send_byte(8'hF0, 1'b0, -1);
        send_bits(mk_frame(8'h3C, 1'b0), 5, -1);
        exp_q.push_back(11'h400);
        mdl_ext = 1'b0;
        mdl_brk = 1'b0;
        wait_cyc(TO + 200);
        d = ev_cyc - last_fall_cyc;
        check("t5_timeout_latency", (d >= TO && d <= TO + 13), 1'b1);
        check_events("t5a");
        send_byte(8'h1C, 1'b0, -1);
        check_events("t5b");

        // 6a: short glitch on PS2_CLK between bits
        send_byte(8'h1D, 1'b0, 4);
        check_events("t6a");

        // 6b: reset mid-frame after a pending E0
        send_byte(8'hE0, 1'b0, -1);
        send_bits(mk_frame(8'h23, 1'b0), 5, -1);
        wait_cyc(5);
        resetn = 1'b0;
        mdl_ext = 1'b0;
        mdl_brk = 1'b0;
        wait_cyc(3);
        check_idle_outputs("t6_reset");
        resetn = 1'b1;
        wait_cyc(HALF);
        check_events("t6b");
        send_byte(8'h23, 1'b0, -1);
        check_events("t6c");

        // randomized frame stream against the model
        for (int i = 0; i < 16; i++) begin
            d = $urandom_range(0, 9);
            if (d < 2)      rb = 8'hE0;
            else if (d < 4) rb = 8'hF0;
            else            rb = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            send_byte(rb, bad, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
        end
        check_events("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
